// File: rtl/mips_multicycle_ctrl.sv
// Control unit for the multicycle MIPS core: Moore sequencer plus ALU decoder.
// Define MIPS_CTRL_BNE_EN to add the BNE state (12); undefined, op 000101 is illegal.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`ifdef MIPS_CTRL_BNE_EN
    , S_BNE  = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             mem_state, last;
  logic             pcwrite, branch, branch_ne;
  logic [1:0]       aluop;

  // Memory states dwell until the wait counter reaches MEM_WAIT; "last" marks the final cycle.
  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign last      = (cnt == CNT_W'(MEM_WAIT));
  assign state_o   = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (last) state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_EXEC;
          OP_BEQ:       state_nx = S_BEQ;
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       state_nx = S_BNE;
`endif
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEMADR: state_nx = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (last) state_nx = S_MEMWB;
      S_MEMWR:  if (last) state_nx = S_FETCH;
      S_EXEC:   state_nx = S_ALUWB;
      S_ADDIEX: state_nx = S_ADDIWB;
      default:  state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) cnt <= '0;
      else if (mem_state && !last) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    aluop     = 2'b00;
    // Reset forces the FETCH selects with every write enable held off.
    if (reset) begin
      alusrcb = 2'b01;
    end else begin
      case (state)
        S_FETCH:  begin alusrcb = 2'b01; irwrite = last; pcwrite = last; end
        S_DECODE: alusrcb = 2'b11;
        S_MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; end
        S_MEMRD:  iord = 1'b1;
        S_MEMWB:  begin memtoreg = 1'b1; regwrite = 1'b1; end
        S_MEMWR:  begin iord = 1'b1; memwrite = last; end
        S_EXEC:   begin alusrca = 1'b1; aluop = 2'b10; end
        S_ALUWB:  begin regdst = 1'b1; regwrite = 1'b1; end
        S_BEQ:    begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
        S_ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
        S_ADDIWB: regwrite = 1'b1;
        S_JUMP:   begin pcsrc = 2'b10; pcwrite = 1'b1; end
`ifdef MIPS_CTRL_BNE_EN
        S_BNE:    begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch_ne = 1'b1; end
`endif
        default:  ;
      endcase
    end
  end

  always_comb begin
    alucontrol = 3'b010;
    if (aluop == 2'b01) alucontrol = 3'b110;
    else if (aluop == 2'b10) begin
      case (funct)
        6'b100010: alucontrol = 3'b110;
        6'b100100: alucontrol = 3'b000;
        6'b100101: alucontrol = 3'b001;
        6'b101010: alucontrol = 3'b111;
        default:   alucontrol = 3'b010;
      endcase
    end
  end

  assign pcen = pcwrite | (branch & zero) | (branch_ne & ~zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: two instances (MEM_WAIT 0 and 2), per-cycle output scoreboard.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       sel = 1'b0;
  logic       rst_drv = 1'b1;
  logic       reset0, reset2;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0;

  logic       pcen0, memwrite0, irwrite0, regwrite0, alusrca0, iord0, memtoreg0, regdst0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] alucontrol0;
  logic [3:0] state0;
  logic       pcen2, memwrite2, irwrite2, regwrite2, alusrca2, iord2, memtoreg2, regdst2;
  logic [1:0] alusrcb2, pcsrc2;
  logic [2:0] alucontrol2;
  logic [3:0] state2;

  logic [18:0] v0, v2;
  logic [18:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // The instance not under test sits in reset.
  assign reset0 = sel ? 1'b1 : rst_drv;
  assign reset2 = sel ? rst_drv : 1'b1;

  mips_multicycle_ctrl #(.MEM_WAIT(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset0), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen0), .memwrite(memwrite0), .irwrite(irwrite0), .regwrite(regwrite0),
    .alusrca(alusrca0), .iord(iord0), .memtoreg(memtoreg0), .regdst(regdst0),
    .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(alucontrol0), .state_o(state0)
  );

  mips_multicycle_ctrl #(.MEM_WAIT(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset2), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen2), .memwrite(memwrite2), .irwrite(irwrite2), .regwrite(regwrite2),
    .alusrca(alusrca2), .iord(iord2), .memtoreg(memtoreg2), .regdst(regdst2),
    .alusrcb(alusrcb2), .pcsrc(pcsrc2), .alucontrol(alucontrol2), .state_o(state2)
  );

  assign v0 = {state0, pcen0, memwrite0, irwrite0, regwrite0, alusrca0, iord0, memtoreg0,
               regdst0, alusrcb0, pcsrc0, alucontrol0};
  assign v2 = {state2, pcen2, memwrite2, irwrite2, regwrite2, alusrca2, iord2, memtoreg2,
               regdst2, alusrcb2, pcsrc2, alucontrol2};

  // Reference: output vector for one cycle spent in state s (table from the state list).
  function automatic logic [18:0] exp_vec(input int s, input bit last, input bit rst,
                                          input logic [5:0] f, input bit z);
    bit pcw = 0, br = 0, brn = 0, mw = 0, irw = 0, rw = 0;
    bit asa = 0, io = 0, m2r = 0, rd = 0, pe;
    logic [1:0] asb = 2'b00, ps = 2'b00, aop = 2'b00;
    logic [2:0] ac;
    if (rst) asb = 2'b01;
    else begin
      case (s)
        0:  begin asb = 2'b01; irw = last; pcw = last; end
        1:  asb = 2'b11;
        2:  begin asa = 1; asb = 2'b10; end
        3:  io = 1;
        4:  begin m2r = 1; rw = 1; end
        5:  begin io = 1; mw = last; end
        6:  begin asa = 1; aop = 2'b10; end
        7:  begin rd = 1; rw = 1; end
        8:  begin asa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
        9:  begin asa = 1; asb = 2'b10; end
        10: rw = 1;
        11: begin ps = 2'b10; pcw = 1; end
        12: begin asa = 1; aop = 2'b01; ps = 2'b01; brn = 1; end
        default: ;
      endcase
    end
    if (aop == 2'b00) ac = 3'b010;
    else if (aop == 2'b01) ac = 3'b110;
    else begin
      case (f)
        6'b100000: ac = 3'b010;
        6'b100010: ac = 3'b110;
        6'b100100: ac = 3'b000;
        6'b100101: ac = 3'b001;
        6'b101010: ac = 3'b111;
        default:   ac = 3'b010;
      endcase
    end
    pe = pcw | (br & z) | (brn & ~z);
    return {4'(s), pe, mw, irw, rw, asa, io, m2r, rd, asb, ps, ac};
  endfunction

  task automatic step(input logic [18:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) step(exp_vec(0, 1'b0, 1'b1, funct, zero), "reset");
    rst_drv = 1'b0;
  endtask

  // Runs one instruction from FETCH; abort_at >= 0 asserts reset during that cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit z,
                           input int w, input int abort_at, input string t);
    int sl[$];
    bit ll[$];
    op = o; funct = f; zero = z;
    for (int i = 0; i <= w; i++) begin sl.push_back(0); ll.push_back(i == w); end
    sl.push_back(1); ll.push_back(1'b1);
    if (o == 6'b100011 || o == 6'b101011) begin
      sl.push_back(2); ll.push_back(1'b1);
      for (int i = 0; i <= w; i++) begin
        sl.push_back(o == 6'b100011 ? 3 : 5);
        ll.push_back(i == w);
      end
      if (o == 6'b100011) begin sl.push_back(4); ll.push_back(1'b1); end
    end else if (o == 6'b000000) begin
      sl.push_back(6); sl.push_back(7); ll.push_back(1'b1); ll.push_back(1'b1);
    end else if (o == 6'b000100) begin
      sl.push_back(8); ll.push_back(1'b1);
    end else if (o == 6'b001000) begin
      sl.push_back(9); sl.push_back(10); ll.push_back(1'b1); ll.push_back(1'b1);
    end else if (o == 6'b000010) begin
      sl.push_back(11); ll.push_back(1'b1);
    end
`ifdef MIPS_CTRL_BNE_EN
    else if (o == 6'b000101) begin
      sl.push_back(12); ll.push_back(1'b1);
    end
`endif
    for (int i = 0; i < sl.size(); i++) begin
      if (i == abort_at) begin
        rst_drv = 1'b1;
        step(exp_vec(sl[i], ll[i], 1'b1, f, z), {t, "_abort"});
        rst_drv = 1'b0;
        return;
      end
      step(exp_vec(sl[i], ll[i], 1'b0, f, z), t);
    end
  endtask

  task automatic run_random(input int n, input int w);
    logic [5:0] o, f;
    logic [5:0] ops[7];
    logic [5:0] fns[5];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000101};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int k = 0; k < n; k++) begin
      o = ($urandom_range(0, 7) == 7) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 6)];
      f = ($urandom_range(0, 1) == 1) ? fns[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      run_instr(o, f, 1'($urandom_range(0, 1)), w, -1, "random");
    end
  endtask

  always @(negedge clk) begin
    logic [18:0] e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = sel ? v2 : v0;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s (dut%0d): got state=%0d vec=%h, expected state=%0d vec=%h",
                 t, sel ? 2 : 0, a[18:15], a, e[18:15], e);
      end
    end
  end

  initial begin
    do_reset(3);
    run_instr(6'b100011, 6'b000000, 1'b0, 0, -1, "lw");
    run_instr(6'b101011, 6'b000000, 1'b0, 0, -1, "sw");
    run_instr(6'b000000, 6'b101010, 1'b0, 0, -1, "rtype_slt");
    run_instr(6'b000000, 6'b100000, 1'b1, 0, -1, "rtype_add");
    run_instr(6'b000000, 6'b100010, 1'b0, 0, -1, "rtype_sub");
    run_instr(6'b000000, 6'b100100, 1'b0, 0, -1, "rtype_and");
    run_instr(6'b000000, 6'b100101, 1'b0, 0, -1, "rtype_or");
    run_instr(6'b000000, 6'b111111, 1'b0, 0, -1, "rtype_badfunct");
    run_instr(6'b000100, 6'b000000, 1'b1, 0, -1, "beq_taken");
    run_instr(6'b000100, 6'b000000, 1'b0, 0, -1, "beq_not_taken");
    run_instr(6'b000010, 6'b000000, 1'b0, 0, -1, "jump");
    run_instr(6'b001000, 6'b000000, 1'b0, 0, -1, "addi");
    run_instr(6'b111111, 6'b000000, 1'b0, 0, -1, "illegal");
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 3, "sw_reset_in_memwr");
    run_instr(6'b000101, 6'b000000, 1'b0, 0, -1, "bne_zero0");
    run_instr(6'b000101, 6'b000000, 1'b1, 0, -1, "bne_zero1");
    run_random(60, 0);

    sel = 1'b1;
    do_reset(3);
    run_instr(6'b101011, 6'b000000, 1'b0, 2, -1, "sw_wait2");
    run_instr(6'b100011, 6'b000000, 1'b0, 2, -1, "lw_wait2");
    run_instr(6'b000000, 6'b101010, 1'b0, 2, -1, "rtype_wait2");
    run_instr(6'b100011, 6'b000000, 1'b0, 2, 5, "lw_wait2_reset_in_memrd");
    run_random(25, 2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
